// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencer: FSM states and EX forwarding selects.
// Pure declarations; no timing or flow-control behaviour of its own.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } hz_state_t;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_NONE = 2'b00;
    localparam fwd_sel_t FWD_W    = 2'b01;
    localparam fwd_sel_t FWD_M    = 2'b10;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// One EX operand's forwarding select from the M and W destinations.
// Purely combinational; no backpressure.
module fwd_sel
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = 4,
    parameter int ZERO_REG_EN = 1
) (
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic [REG_ADDR_W-1:0] rd_m_i,
    input  logic [REG_ADDR_W-1:0] rd_w_i,
    input  logic                  reg_write_m_i,
    input  logic                  reg_write_w_i,
    output logic [1:0]            sel_o
);

    logic m_hit;
    logic w_hit;

    assign m_hit = reg_write_m_i && ((ZERO_REG_EN == 0) || (rd_m_i != '0)) && (rd_m_i == rs_i);
    assign w_hit = reg_write_w_i && ((ZERO_REG_EN == 0) || (rd_w_i != '0)) && (rd_w_i == rs_i);

    // M holds the younger result, so it wins over W.
    always_comb begin
        sel_o = FWD_NONE;
        if (m_hit) begin
            sel_o = FWD_M;
        end else if (w_hit) begin
            sel_o = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline sequencer: stall/flush controls, EX forwarding and the M-stage memory handshake.
// Controls are combinational same-cycle; ERROR and STALL_CNT are registered (one cycle).
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = 4,
    parameter int ZERO_REG_EN = 1,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                  CLK,
    input  logic                  CLR_N,
    input  logic [REG_ADDR_W-1:0] RS1_D,
    input  logic [REG_ADDR_W-1:0] RS2_D,
    input  logic [REG_ADDR_W-1:0] RS1_E,
    input  logic [REG_ADDR_W-1:0] RS2_E,
    input  logic [REG_ADDR_W-1:0] RD_E,
    input  logic [REG_ADDR_W-1:0] RD_M,
    input  logic [REG_ADDR_W-1:0] RD_W,
    input  logic                  REG_WRITE_E,
    input  logic                  REG_WRITE_M,
    input  logic                  REG_WRITE_W,
    input  logic                  MEM_TO_REG_E,
    input  logic                  MEM_OP_M,
    input  logic                  BRANCH_TAKEN_E,
    input  logic                  MEM_READY,
    output logic                  MEM_REQ,
    output logic                  STALL_F,
    output logic                  STALL_D,
    output logic                  STALL_E,
    output logic                  STALL_M,
    output logic                  FLUSH_D,
    output logic                  FLUSH_E,
    output logic [1:0]            FWD_A_E,
    output logic [1:0]            FWD_B_E,
    output logic                  ERROR,
    output logic [CNT_W-1:0]      STALL_CNT
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_t          state_q, state_d;
    logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               error_q, error_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic       mem_req, mem_hold, load_use;
    logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;
    logic [1:0] fwd_a, fwd_b;

    assign load_use = REG_WRITE_E && MEM_TO_REG_E
                   && ((ZERO_REG_EN == 0) || (RD_E != '0))
                   && ((RD_E == RS1_D) || (RD_E == RS2_D));

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        error_d    = error_q;
        mem_req    = 1'b0;
        mem_hold   = 1'b0;
        unique case (state_q)
            RUN: begin
                mem_req = MEM_OP_M;
                if (MEM_OP_M && !MEM_READY) begin
                    mem_hold   = 1'b1;
                    state_d    = WAIT;
                    wait_cnt_d = WCNT_W'(1);
                end
            end
            WAIT: begin
                mem_req = 1'b1;
                // The ready cycle itself releases the pipeline.
                if (MEM_READY) begin
                    state_d = RUN;
                end else begin
                    mem_hold = 1'b1;
                    if (wait_cnt_q == WCNT_W'(MEM_TIMEOUT)) begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                    end
                end
            end
            ERR: begin
                mem_hold = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        // A frozen E stage means branch/load-use get re-evaluated once memory releases.
        if (mem_hold) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
        end else if (BRANCH_TAKEN_E) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    assign stall_cnt_d = (stall_f && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

    always_ff @(posedge CLK) begin
        if (!CLR_N) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            error_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            error_q     <= error_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    fwd_sel #(.REG_ADDR_W(REG_ADDR_W), .ZERO_REG_EN(ZERO_REG_EN)) u_fwd_a (
        .rs_i(RS1_E), .rd_m_i(RD_M), .rd_w_i(RD_W),
        .reg_write_m_i(REG_WRITE_M), .reg_write_w_i(REG_WRITE_W), .sel_o(fwd_a)
    );

    fwd_sel #(.REG_ADDR_W(REG_ADDR_W), .ZERO_REG_EN(ZERO_REG_EN)) u_fwd_b (
        .rs_i(RS2_E), .rd_m_i(RD_M), .rd_w_i(RD_W),
        .reg_write_m_i(REG_WRITE_M), .reg_write_w_i(REG_WRITE_W), .sel_o(fwd_b)
    );

    // Reset overrides everything: bubbles into F/D and D/E, all else quiet.
    assign MEM_REQ   = CLR_N && mem_req;
    assign STALL_F   = CLR_N && stall_f;
    assign STALL_D   = CLR_N && stall_d;
    assign STALL_E   = CLR_N && stall_e;
    assign STALL_M   = CLR_N && stall_m;
    assign FLUSH_D   = !CLR_N || flush_d;
    assign FLUSH_E   = !CLR_N || flush_e;
    assign FWD_A_E   = CLR_N ? fwd_a : FWD_NONE;
    assign FWD_B_E   = CLR_N ? fwd_b : FWD_NONE;
    assign ERROR     = CLR_N && error_q;
    assign STALL_CNT = CLR_N ? stall_cnt_q : '0;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MEM_TIMEOUT=8, CNT_W=4).
module tb_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    logic       CLK = 1'b0;
    logic       CLR_N;
    logic [3:0] RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
    logic       REG_WRITE_E, REG_WRITE_M, REG_WRITE_W, MEM_TO_REG_E;
    logic       MEM_OP_M, BRANCH_TAKEN_E, MEM_READY;
    logic       MEM_REQ, STALL_F, STALL_D, STALL_E, STALL_M, FLUSH_D, FLUSH_E, ERROR;
    logic [1:0] FWD_A_E, FWD_B_E;
    logic [3:0] STALL_CNT;
    logic [6:0] ctl;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    always #5 CLK = ~CLK;

    hazard_ctrl #(.REG_ADDR_W(4), .ZERO_REG_EN(1), .MEM_TIMEOUT(8), .CNT_W(4)) dut (
        .CLK(CLK), .CLR_N(CLR_N),
        .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E),
        .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W),
        .REG_WRITE_E(REG_WRITE_E), .REG_WRITE_M(REG_WRITE_M), .REG_WRITE_W(REG_WRITE_W),
        .MEM_TO_REG_E(MEM_TO_REG_E), .MEM_OP_M(MEM_OP_M), .BRANCH_TAKEN_E(BRANCH_TAKEN_E),
        .MEM_READY(MEM_READY), .MEM_REQ(MEM_REQ),
        .STALL_F(STALL_F), .STALL_D(STALL_D), .STALL_E(STALL_E), .STALL_M(STALL_M),
        .FLUSH_D(FLUSH_D), .FLUSH_E(FLUSH_E), .FWD_A_E(FWD_A_E), .FWD_B_E(FWD_B_E),
        .ERROR(ERROR), .STALL_CNT(STALL_CNT)
    );

    assign ctl = {MEM_REQ, STALL_F, STALL_D, STALL_E, STALL_M, FLUSH_D, FLUSH_E};

    // Stimulus must never drop MEM_OP_M while the handshake is waiting.
    always @(negedge CLK) begin
        if (CLR_N === 1'b1 && dut.state_q == WAIT && MEM_OP_M !== 1'b1) begin
            failures++;
            $display("FAIL mem_op_drop_in_wait MEM_OP_M=%b required=1", MEM_OP_M);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        RS1_D = 0; RS2_D = 0; RS1_E = 0; RS2_E = 0; RD_E = 0; RD_M = 0; RD_W = 0;
        REG_WRITE_E = 0; REG_WRITE_M = 0; REG_WRITE_W = 0; MEM_TO_REG_E = 0;
        MEM_OP_M = 0; BRANCH_TAKEN_E = 0; MEM_READY = 0;
    endtask

    task automatic test_reset();
        CLR_N = 1'b0;
        idle_inputs();
        tick();
        MEM_OP_M = 1; BRANCH_TAKEN_E = 1; RS1_E = 3; RD_M = 3; REG_WRITE_M = 1;
        #1;
        checks++;
        if (ctl !== 7'b0000011) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 7'b0000011); end
        checks++;
        if (FWD_A_E !== 2'b00 || ERROR !== 1'b0 || STALL_CNT !== 4'd0) begin
            failures++; $display("FAIL reset_misc fwd=%b err=%b cnt=%0d exp=00/0/0", FWD_A_E, ERROR, STALL_CNT);
        end
        tick();
        CLR_N = 1'b1;
        idle_inputs();
        #1;
        checks++;
        if (ctl !== 7'b0 || ERROR !== 1'b0 || STALL_CNT !== 4'd0) begin
            failures++; $display("FAIL post_reset ctl=%b err=%b cnt=%0d exp=0000000/0/0", ctl, ERROR, STALL_CNT);
        end
        exp_cnt = 0;
    endtask

    task automatic test_load_use();
        REG_WRITE_E = 1; MEM_TO_REG_E = 1; RD_E = 5; RS1_D = 5; RS2_D = 2;
        #1;
        checks++;
        if (ctl !== 7'b0110001) begin failures++; $display("FAIL load_use_rs1 got=%b exp=%b", ctl, 7'b0110001); end
        tick(); exp_cnt++;
        RD_E = 7; RS1_D = 1; RS2_D = 7;
        #1;
        checks++;
        if (ctl !== 7'b0110001) begin failures++; $display("FAIL load_use_rs2 got=%b exp=%b", ctl, 7'b0110001); end
        tick(); exp_cnt++;
        RD_E = 0; RS1_D = 0; RS2_D = 0;
        #1;
        checks++;
        if (ctl !== 7'b0) begin failures++; $display("FAIL load_use_zero_reg got=%b exp=%b", ctl, 7'b0); end
        RD_E = 5; RS1_D = 5; MEM_TO_REG_E = 0;
        #1;
        checks++;
        if (ctl !== 7'b0) begin failures++; $display("FAIL load_use_not_load got=%b exp=%b", ctl, 7'b0); end
        checks++;
        if (STALL_CNT !== 4'(exp_cnt)) begin failures++; $display("FAIL load_use_cnt got=%0d exp=%0d", STALL_CNT, exp_cnt); end
        idle_inputs();
    endtask

    task automatic test_branch();
        REG_WRITE_E = 1; MEM_TO_REG_E = 1; RD_E = 5; RS1_D = 5; BRANCH_TAKEN_E = 1;
        #1;
        checks++;
        if (ctl !== 7'b0000011) begin failures++; $display("FAIL branch_over_load_use got=%b exp=%b", ctl, 7'b0000011); end
        idle_inputs();
    endtask

    task automatic test_forward();
        RS1_E = 3; RS2_E = 0; RD_M = 3; RD_W = 3; REG_WRITE_M = 1; REG_WRITE_W = 1;
        #1;
        checks++;
        if (FWD_A_E !== 2'b10 || FWD_B_E !== 2'b00) begin failures++; $display("FAIL fwd_m_wins a=%b b=%b exp=10/00", FWD_A_E, FWD_B_E); end
        REG_WRITE_M = 0;
        #1;
        checks++;
        if (FWD_A_E !== 2'b01) begin failures++; $display("FAIL fwd_w got=%b exp=01", FWD_A_E); end
        RD_W = 4; RS2_E = 4;
        #1;
        checks++;
        if (FWD_A_E !== 2'b00 || FWD_B_E !== 2'b01) begin failures++; $display("FAIL fwd_none_b_w a=%b b=%b exp=00/01", FWD_A_E, FWD_B_E); end
        REG_WRITE_M = 1; RD_M = 4;
        #1;
        checks++;
        if (FWD_A_E !== 2'b00 || FWD_B_E !== 2'b10) begin failures++; $display("FAIL fwd_b_m a=%b b=%b exp=00/10", FWD_A_E, FWD_B_E); end
        RS1_E = 0; RS2_E = 0; RD_M = 0; RD_W = 0; REG_WRITE_W = 1;
        #1;
        checks++;
        if (FWD_A_E !== 2'b00 || FWD_B_E !== 2'b00) begin failures++; $display("FAIL fwd_zero_reg a=%b b=%b exp=00/00", FWD_A_E, FWD_B_E); end
        idle_inputs();
    endtask

    task automatic test_mem_latency();
        MEM_OP_M = 1; MEM_READY = 1;
        #1;
        checks++;
        if (ctl !== 7'b1000000) begin failures++; $display("FAIL mem_ready_run got=%b exp=%b", ctl, 7'b1000000); end
        tick();
        MEM_READY = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ctl !== 7'b1111100) begin failures++; $display("FAIL mem_wait_c%0d got=%b exp=%b", i, ctl, 7'b1111100); end
            tick(); exp_cnt++;
        end
        MEM_READY = 1;
        #1;
        checks++;
        if (ctl !== 7'b1000000) begin failures++; $display("FAIL mem_ready_wait got=%b exp=%b", ctl, 7'b1000000); end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (ctl !== 7'b0 || STALL_CNT !== 4'(exp_cnt)) begin
            failures++; $display("FAIL mem_back_in_run ctl=%b cnt=%0d exp=0000000/%0d", ctl, STALL_CNT, exp_cnt);
        end
    endtask

    task automatic test_branch_during_wait();
        MEM_OP_M = 1; MEM_READY = 0; BRANCH_TAKEN_E = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (ctl !== 7'b1111100) begin failures++; $display("FAIL br_wait_c%0d got=%b exp=%b", i, ctl, 7'b1111100); end
            tick(); exp_cnt++;
        end
        MEM_READY = 1;
        #1;
        checks++;
        if (ctl !== 7'b1000011) begin failures++; $display("FAIL br_wait_release got=%b exp=%b", ctl, 7'b1000011); end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (STALL_CNT !== 4'(exp_cnt)) begin failures++; $display("FAIL br_wait_cnt got=%0d exp=%0d", STALL_CNT, exp_cnt); end
    endtask

    task automatic test_timeout();
        MEM_OP_M = 1; MEM_READY = 0;
        // One RUN stall cycle then eight WAIT cycles before the timeout.
        for (int i = 0; i < 9; i++) begin
            #1;
            checks++;
            if (ctl !== 7'b1111100 || ERROR !== 1'b0) begin
                failures++; $display("FAIL timeout_wait_c%0d ctl=%b err=%b exp=1111100/0", i, ctl, ERROR);
            end
            tick(); exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
        end
        BRANCH_TAKEN_E = 1;
        #1;
        checks++;
        if (ctl !== 7'b0111100 || ERROR !== 1'b1) begin
            failures++; $display("FAIL timeout_err ctl=%b err=%b exp=0111100/1", ctl, ERROR);
        end
        checks++;
        if (STALL_CNT !== 4'(exp_cnt)) begin failures++; $display("FAIL timeout_cnt got=%0d exp=%0d", STALL_CNT, exp_cnt); end
        MEM_READY = 1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (ctl !== 7'b0111100 || ERROR !== 1'b1 || STALL_CNT !== 4'd15) begin
            failures++; $display("FAIL err_sticky ctl=%b err=%b cnt=%0d exp=0111100/1/15", ctl, ERROR, STALL_CNT);
        end
        CLR_N = 1'b0;
        #1;
        checks++;
        if (ctl !== 7'b0000011 || ERROR !== 1'b0) begin
            failures++; $display("FAIL err_in_reset ctl=%b err=%b exp=0000011/0", ctl, ERROR);
        end
        tick();
        CLR_N = 1'b1;
        idle_inputs();
        MEM_OP_M = 1; MEM_READY = 1;
        #1;
        checks++;
        if (ctl !== 7'b1000000 || ERROR !== 1'b0 || STALL_CNT !== 4'd0) begin
            failures++; $display("FAIL err_cleared ctl=%b err=%b cnt=%0d exp=1000000/0/0", ctl, ERROR, STALL_CNT);
        end
        idle_inputs();
        exp_cnt = 0;
    endtask

    task automatic test_saturate();
        MEM_OP_M = 1; MEM_READY = 0;
        for (int i = 0; i < 14; i++) tick();
        checks++;
        if (STALL_CNT !== 4'd14) begin failures++; $display("FAIL sat_cnt14 got=%0d exp=14", STALL_CNT); end
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (STALL_CNT !== 4'd15) begin failures++; $display("FAIL sat_cnt20 got=%0d exp=15", STALL_CNT); end
        CLR_N = 1'b0;
        tick();
        CLR_N = 1'b1;
        idle_inputs();
        #1;
        checks++;
        if (STALL_CNT !== 4'd0 || ERROR !== 1'b0) begin
            failures++; $display("FAIL sat_reset cnt=%0d err=%b exp=0/0", STALL_CNT, ERROR);
        end
    endtask

    task automatic test_reset_mid_wait();
        MEM_OP_M = 1; MEM_READY = 0;
        tick();
        tick();
        CLR_N = 1'b0;
        #1;
        checks++;
        if (ctl !== 7'b0000011) begin failures++; $display("FAIL midwait_in_reset got=%b exp=%b", ctl, 7'b0000011); end
        tick();
        CLR_N = 1'b1;
        idle_inputs();
        #1;
        checks++;
        if (ctl !== 7'b0 || STALL_CNT !== 4'd0 || ERROR !== 1'b0) begin
            failures++; $display("FAIL midwait_run ctl=%b cnt=%0d err=%b exp=0000000/0/0", ctl, STALL_CNT, ERROR);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_forward();
        test_mem_latency();
        test_branch_during_wait();
        test_timeout();
        test_saturate();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
